divuint_seq: RTL

- Parametrised successor to the current divider interface: an iterative unsigned restoring divider with a built-in operand/result handshake.
- Produces quotient, remainder and a divide-by-zero flag.
- Adds an auto mode that recomputes only when the operands change. Unchanged operands cause no recompute.
- Sits between free-running counter/timer datapaths and display/compare logic.

---
 rtl/divuint_seq.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/divuint_seq.sv
// Iterative unsigned restoring divider (one quotient bit per clock, MSB first)
// with an operand/result handshake, or an auto mode that recomputes only when the operands change.
module divuint_seq #(
  parameter int unsigned WIDTH     = 10,
  parameter bit          AUTO_MODE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             dbz,
  output logic             busy
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_state_next;

  // r_a holds the dividend. Each step shifts one dividend bit out of the top
  // and one quotient bit in at the bottom, so after WIDTH steps it holds the quotient.
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_prem;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_rem;
  logic             r_dbz;
  logic             r_first;
  logic [WIDTH-1:0] r_last_a;
  logic [WIDTH-1:0] r_last_b;

  logic             w_start;
  logic             w_div_zero;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH-1:0] w_diff;
  logic             w_qbit;
  logic [WIDTH-1:0] w_prem_next;
  logic [WIDTH-1:0] w_a_next;

  assign in_ready   = (r_state == S_IDLE) && (AUTO_MODE == 1'b0);
  assign busy       = (r_state == S_CALC);
  assign out_valid  = (r_state == S_DONE);
  assign quotient   = r_quot;
  assign remainder  = r_rem;
  assign dbz        = r_dbz;
  assign w_div_zero = (divisor == '0);

  generate
    if (AUTO_MODE) begin : g_auto_start
      assign w_start = (r_state == S_IDLE) &&
                       (r_first || (dividend != r_last_a) || (divisor != r_last_b));
    end else begin : g_hs_start
      assign w_start = in_valid && in_ready;
    end
  endgenerate

  // One restoring step. The partial remainder stays below the divisor, so the shifted
  // value fits in WIDTH+1 bits. A successful trial difference always fits in WIDTH bits.
  assign w_shift     = {r_prem, r_a[WIDTH-1]};
  assign w_qbit      = (w_shift >= {1'b0, r_b});
  assign w_diff      = w_shift[WIDTH-1:0] - r_b;
  assign w_prem_next = w_qbit ? w_diff : w_shift[WIDTH-1:0];
  assign w_a_next    = {r_a[WIDTH-2:0], w_qbit};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // NOTE: every output of a combinational block gets a default first, so no path
  // leaves it unassigned and infers a latch.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_state_next = w_div_zero ? S_DONE : S_CALC;
        end
      end
      S_CALC: begin
        if (r_cnt == LAST_STEP) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        if (AUTO_MODE || out_ready) begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only. Every register samples
  // the values from before the edge, whatever order the statements appear in.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_prem   <= '0;
      r_cnt    <= '0;
      r_quot   <= '0;
      r_rem    <= '0;
      r_dbz    <= 1'b0;
      r_first  <= 1'b1;
      r_last_a <= '0;
      r_last_b <= '0;
    end else if (w_start) begin
      r_a     <= dividend;
      r_b     <= divisor;
      r_first <= 1'b0;
      if (AUTO_MODE) begin
        r_last_a <= dividend;
        r_last_b <= divisor;
      end
      if (w_div_zero) begin
        r_quot <= '0;
        r_rem  <= dividend;
        r_dbz  <= 1'b1;
      end else begin
        r_cnt  <= '0;
        r_prem <= '0;
      end
    end else if (r_state == S_CALC) begin
      r_a    <= w_a_next;
      r_prem <= w_prem_next;
      r_cnt  <= r_cnt + 1'b1;
      // Visible results change only on entry to DONE, so the previous result holds during CALC.
      if (r_cnt == LAST_STEP) begin
        r_quot <= w_a_next;
        r_rem  <= w_prem_next;
        r_dbz  <= 1'b0;
      end
    end
  end

endmodule
